// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage constants and the IF/ID pipeline record
package mips_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;
  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
endpackage

// File: rtl/fetch_ifid_reg.sv
// fetch_ifid_reg: IF/ID pipeline register with async reset, stall-hold and flush-to-bubble
module fetch_ifid_reg
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  stall,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);
  // flush outranks stall so a squashed slot never lingers while the front end is frozen
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= BUBBLE;
    else if (flush) q <= BUBBLE;
    else if (!stall) q <= d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, next-PC selection and IF/ID register; FETCH_ADDR_CHECK_EN adds a sticky fetch_err
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fetch_err
);
  logic [31:0] pc_plus4, raw_target, next_pc;
  logic redirect;
  ifid_t ifid_d, ifid_q;
  // branch beats jump; targets are word-aligned before use
  always_comb begin
    pc_plus4 = pc_f + PC_STEP;
    redirect = branch_taken | jump;
    raw_target = branch_taken ? branch_target : jump_target;
    next_pc = redirect ? (raw_target & ~32'h3) : pc_plus4;
    ifid_d = '{instr: instr_f, pc_plus4: pc_plus4, valid: 1'b1};
  end
  // a stall freezes the PC and drops any redirect presented during it
  always_ff @(posedge clk or posedge rst)
    if (rst) pc_f <= RESET_PC;
    else if (!stall_f) pc_f <= next_pc;
  fetch_ifid_reg u_ifid (
    .clk  (clk),
    .rst  (rst),
    .stall(stall_f),
    .flush(flush_d),
    .d    (ifid_d),
    .q    (ifid_q)
  );
  assign instr_d = ifid_q.instr;
  assign pc_plus4_d = ifid_q.pc_plus4;
  assign valid_d = ifid_q.valid;
`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [29:0] IMEM_LIM = 30'(IMEM_WORDS);
  // sticky: misaligned taken redirect or fetch beyond the memory, checked only on unstalled edges
  always_ff @(posedge clk or posedge rst)
    if (rst) fetch_err <= 1'b0;
    else if (!stall_f && ((redirect && raw_target[1:0] != 2'b00) || pc_f[31:2] >= IMEM_LIM)) fetch_err <= 1'b1;
`else
  assign fetch_err = 1'b0 && (IMEM_WORDS != 0);
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table vectors, directed corners and random stimulus against a fetch model
module tb_fetch_stage;
`ifdef FETCH_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic stall_f = 0, flush_d = 0, branch_taken = 0, jump = 0;
  logic [31:0] branch_target = 0, jump_target = 0, instr_f;
  logic [31:0] pc_f, instr_d, pc_plus4_d;
  logic valid_d, fetch_err;
  int tests = 0, fails = 0;
  logic [31:0] m_pc, m_instr, m_p4;
  logic m_valid, m_err;

  fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(128)) dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .flush_d(flush_d),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instr_f(instr_f),
    .pc_f(pc_f), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // instruction memory contents: word i holds 0x20080001 + i (128 words, address bits [8:2])
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h2008_0001 + {25'd0, a[8:2]};
  endfunction
  assign instr_f = memf(pc_f);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc_f"}, pc_f, m_pc);
    chk({tag, ".instr_d"}, instr_d, m_instr);
    chk({tag, ".pc_plus4_d"}, pc_plus4_d, m_p4);
    chk({tag, ".valid_d"}, 32'(valid_d), 32'(m_valid));
    chk({tag, ".fetch_err"}, 32'(fetch_err), 32'(m_err));
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  // assert reset for one edge, check the forced values, release
  task automatic do_reset();
    rst = 1'b1;
    {stall_f, flush_d, branch_taken, jump} = '0;
    @(posedge clk); #1;
    model_reset();
    chk_all("reset");
    rst = 1'b0;
  endtask

  // apply one cycle of inputs, advance the model by the fetch rules, compare after the edge
  task automatic cyc(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                     input logic jp, input logic [31:0] jt, input string tag);
    logic [31:0] tgt;
    stall_f = st; flush_d = fl; branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
    tgt = br ? bt : jt;
    if (CHK && !st && (((br || jp) && tgt[1:0] != 2'b00) || (m_pc >> 2) >= 128)) m_err = 1'b1;
    if (fl) begin
      m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = memf(m_pc); m_p4 = m_pc + 4; m_valid = 1'b1;
    end
    if (!st) m_pc = (br || jp) ? {tgt[31:2], 2'b00} : m_pc + 4;
    @(posedge clk); #1;
    chk_all(tag);
  endtask

  typedef struct {
    logic st, fl, br;
    logic [31:0] bt;
    logic jp;
    logic [31:0] jt, epc, ein, ep4;
    logic ev;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mk(input logic st, fl, br, input logic [31:0] bt, input logic jp,
                              input logic [31:0] jt, epc, ein, ep4, input logic ev);
    vec_t v;
    v.st = st; v.fl = fl; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
    v.epc = epc; v.ein = ein; v.ep4 = ep4; v.ev = ev;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(0, 0, 0, 0,     0, 0,     32'h04, 32'h2008_0001, 32'h04, 1);
    tbl[1]  = mk(0, 0, 0, 0,     0, 0,     32'h08, 32'h2008_0002, 32'h08, 1);
    tbl[2]  = mk(0, 1, 1, 32'h40, 0, 0,    32'h40, 32'h0,         32'h00, 0);
    tbl[3]  = mk(0, 0, 0, 0,     0, 0,     32'h44, 32'h2008_0011, 32'h44, 1);
    tbl[4]  = mk(1, 0, 0, 0,     1, 32'h20, 32'h44, 32'h2008_0011, 32'h44, 1);
    tbl[5]  = mk(1, 0, 0, 0,     1, 32'h20, 32'h44, 32'h2008_0011, 32'h44, 1);
    tbl[6]  = mk(1, 0, 0, 0,     1, 32'h20, 32'h44, 32'h2008_0011, 32'h44, 1);
    tbl[7]  = mk(0, 0, 0, 0,     1, 32'h20, 32'h20, 32'h2008_0012, 32'h48, 1);
    tbl[8]  = mk(1, 1, 0, 0,     0, 0,     32'h20, 32'h0,         32'h00, 0);
    tbl[9]  = mk(0, 0, 0, 0,     0, 0,     32'h24, 32'h2008_0009, 32'h24, 1);
    tbl[10] = mk(0, 1, 1, 32'h10, 1, 32'h30, 32'h10, 32'h0,       32'h00, 0);
    tbl[11] = mk(0, 0, 0, 0,     0, 0,     32'h14, 32'h2008_0005, 32'h14, 1);

    #2;
    chk("async_reset.pc_f", pc_f, 32'h0);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].st, tbl[i].fl, tbl[i].br, tbl[i].bt, tbl[i].jp, tbl[i].jt, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_pc", i), pc_f, tbl[i].epc);
      chk($sformatf("vec%0d.tbl_instr", i), instr_d, tbl[i].ein);
      chk($sformatf("vec%0d.tbl_p4", i), pc_plus4_d, tbl[i].ep4);
      chk($sformatf("vec%0d.tbl_valid", i), 32'(valid_d), 32'(tbl[i].ev));
    end

    // wrap from the top of the address space
    cyc(0, 1, 0, 0, 1, 32'hFFFF_FFFC, "wrap_jump");
    chk("wrap_jump.pc", pc_f, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0, "wrap");
    chk("wrap.pc", pc_f, 32'h0);
    chk("wrap.pc_plus4_d", pc_plus4_d, 32'h0);

    // mid-cycle asynchronous reset takes effect before the next edge
    cyc(0, 0, 0, 0, 0, 0, "pre_rst");
    #2 rst = 1'b1;
    #1;
    chk("midrst.pc_f", pc_f, 32'h0);
    chk("midrst.instr_d", instr_d, 32'h0);
    chk("midrst.valid_d", 32'(valid_d), 32'h0);
    chk("midrst.pc_plus4_d", pc_plus4_d, 32'h0);
    @(posedge clk); #1;
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, "post_rst");
    chk("post_rst.instr_d", instr_d, 32'h2008_0001);

    // fetch-address checks (must stay 0 without the feature)
    cyc(0, 1, 0, 0, 1, 32'h0000_0022, "mis_jump");
    chk("mis_jump.pc", pc_f, 32'h20);
    chk("mis_jump.err", 32'(fetch_err), 32'(CHK));
    do_reset();
    cyc(0, 1, 0, 0, 1, 32'h200, "far_jump");
    chk("far_jump.err", 32'(fetch_err), 32'h0);
    cyc(0, 0, 0, 0, 0, 0, "far_fetch");
    chk("far_fetch.err", 32'(fetch_err), 32'(CHK));
    cyc(1, 0, 0, 0, 0, 0, "err_sticky");
    do_reset();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic st, fl, br, jp;
      logic [31:0] bt, jt;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 4) == 0);
      jp = ($urandom_range(0, 4) == 0);
      bt = {$urandom_range(0, 140), 2'(CHK ? $urandom_range(0, 3) : 0)};
      jt = {$urandom_range(0, 140), 2'(CHK ? $urandom_range(0, 3) : 0)};
      if (n % 97 == 96) begin
        do_reset();
      end else begin
        cyc(st, fl, br, bt, jp, jt, $sformatf("rnd%0d", n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the program counter and drives `pc_f` to the combinational instruction memory.
- Takes the returned word `instr_f` and registers it, with `pc+4`, into the IF/ID pipeline register consumed by decode.
- Applies hazard-unit stall/flush and decode-stage branch/jump redirects.

Parameters:
- `RESET_PC`, `32'h0000_0000`: PC value loaded on reset.
- `IMEM_WORDS`, `128`: instruction memory depth in words. Used only by the optional range check.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `stall_f`, input, 1: hold the PC and the IF/ID register.
- `flush_d`, input, 1: replace the IF/ID contents with a bubble.
- `branch_taken`, input, 1: decode resolved a taken branch.
- `branch_target`, input, 32: branch destination address.
- `jump`, input, 1: decode holds a `j`/`jal`.
- `jump_target`, input, 32: jump destination address.
- `instr_f`, input, 32: word returned by instruction memory for `pc_f`.
- `pc_f`, output, 32: current fetch address to instruction memory.
- `instr_d`, output, 32: registered instruction to decode.
- `pc_plus4_d`, output, 32: registered `pc+4` of `instr_d`.
- `valid_d`, output, 1: `instr_d` is a real instruction, not a bubble.
- `fetch_err`, output, 1: sticky fetch-address error. Meaningful only with the optional feature.

Behaviour:
- **Reset.** One clock; reset is asynchronous and active-high. Asserting `rst` immediately forces:
  - `pc_f = RESET_PC`
  - `instr_d = 32'h0000_0000` (NOP)
  - `pc_plus4_d = 0`, `valid_d = 0`, `fetch_err = 0`
- **Reset release and mid-operation reset.** After release, the first edge latches `instr_f` at `RESET_PC`. Reset mid-operation discards all in-flight state; there is no partial completion.
- **`pc_plus4`.** Computed as `pc_f + 4` modulo 2^32. From `32'hFFFF_FFFC` it wraps to `32'h0000_0000`.
- **Next-PC priority** (highest first):
  1. `branch_taken` → `branch_target`
  2. `jump` → `jump_target`
  3. otherwise → `pc_plus4`
  - If `branch_taken` and `jump` are both asserted, the branch wins.
- **Target alignment.** Bits [1:0] of any selected target are forced to 2'b00 before loading.
- **PC update.** On each edge with `stall_f = 0`, `pc_f` loads next-PC. With `stall_f = 1`, `pc_f` holds.
  - Redirects asserted while `stall_f = 1` are ignored. The hazard unit must keep them asserted until the stall drops.
- **IF/ID update** (priority order):
  - `flush_d = 1`: load the bubble (`instr_d = 0`, `pc_plus4_d = 0`, `valid_d = 0`). Flush beats stall.
  - `stall_f = 1`: hold all three outputs.
  - otherwise: `instr_d <= instr_f`, `pc_plus4_d <= pc_f + 4`, `valid_d <= 1`.
- **Latency.**
  - Instruction at `pc_f` appears on `instr_d` one cycle later.
  - A redirect sampled at edge N makes `pc_f = target` after edge N. The target's instruction reaches `instr_d` after edge N+1.
  - The wrong-path word fetched during cycle N is removed only if decode asserts `flush_d` at edge N. The hazard unit drives `flush_d` together with any redirect.
- **No handshake with memory.** `instr_f` is assumed valid in the same cycle as `pc_f`.

Optional Feature:
- Macro: `FETCH_ADDR_CHECK_EN`.
- **Defined:**
  - `fetch_err` sets when a selected branch/jump target has nonzero bits [1:0]. It is checked before alignment forcing, and only when the redirect is taken (not stalled).
  - `fetch_err` also sets when `pc_f[31:2] >= IMEM_WORDS` on any unstalled edge.
  - `fetch_err` is sticky until `rst`. PC behaviour is unchanged.
- **Undefined:** `fetch_err` is tied to 0 and no check logic is synthesised.

Decomposition:
- Package `mips_pkg` holds:
  - constants `NOP_INSTR = 32'h0000_0000` and `PC_STEP = 4`
  - typedef `ifid_t` as a packed struct {`instr[31:0]`, `pc_plus4[31:0]`, `valid`}
- One sub-module, `fetch_ifid_reg`: the IF/ID register with async reset, stall-hold and flush-to-bubble, operating on `ifid_t`.
- Next-PC mux and PC register stay in `fetch_stage`.

Test Plan:
1. **Reset, then sequential run.** `rst` pulse, memory words 0..3 = `0x20080001`.. → `pc_f` = 0, 4, 8, 12 on successive cycles; `instr_d` trails by 1 cycle; `valid_d` = 1 from the second edge.
2. **Branch with flush.** At `pc_f = 8`, `branch_taken = 1`, `branch_target = 0x40`, `flush_d = 1` → next `pc_f = 0x40`; `instr_d = 0` with `valid_d = 0` for one cycle; word at `0x40` appears on the following edge.
3. **Stall/flush interaction.**
   - `stall_f = 1` for 3 cycles with `jump = 1`, `jump_target = 0x20` → `pc_f` and `instr_d` frozen and the jump ignored.
   - Then `stall_f = 0` → `pc_f = 0x20`.
   - `stall_f = 1` together with `flush_d = 1` → `valid_d = 0`.
4. **Branch and jump together.** `branch_target = 0x10`, `jump_target = 0x30` → `pc_f = 0x10`.
5. **Wrap and async reset.** Force `pc_f = 0xFFFF_FFFC` via a jump → next `pc_f = 0`. Assert `rst` mid-cycle → `pc_f = RESET_PC` before the next clock edge.
6. **Address check (`FETCH_ADDR_CHECK_EN` defined).** Jump to `0x0000_0022` → `pc_f = 0x20` and `fetch_err = 1`. Fetch at `0x200` with `IMEM_WORDS = 128` → `fetch_err = 1`. Without the macro → `fetch_err` stays 0.
